// File: rtl/ofdm_pkg.sv
// ofdm_pkg
//   Shared types and constants for the OFDM cyclic-prefix inserter.
//   - DATA_W_DEF : default width of one real/imaginary component.
//   - sample_t   : one complex time-domain sample (real, imag).
//   - wr_state_t : write-side framing FSM states (HUNT, FILL).
//   - rd_state_t : read-side emission FSM states (IDLE, CP, BODY[, SUFFIX]).
//   Optional feature macro: OFDM_CP_SUFFIX_EN adds the SUFFIX read state.
package ofdm_pkg;

    localparam int DATA_W_DEF = 14;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } sample_t;

    typedef enum logic {
        W_HUNT,
        W_FILL
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CP,
        R_BODY
`ifdef OFDM_CP_SUFFIX_EN
        , R_SUFFIX
`endif
    } rd_state_t;

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// ofdm_pingpong_ram
//   Two-bank simple dual-port RAM holding one OFDM symbol per bank.
//   The bank select is the address MSB; the read port is registered.
//   Ports:
//     clk      in  system clock
//     wr_en    in  write strobe
//     wr_addr  in  {bank, index} write address
//     wr_data  in  {real, imag} sample to store
//     rd_en    in  read strobe; rd_data holds its value while low
//     rd_addr  in  {bank, index} read address
//     rd_data  out registered read data (one cycle after rd_en)
module ofdm_pingpong_ram
    import ofdm_pkg::*;
#(
    parameter int WIDTH = 2 * DATA_W_DEF,
    parameter int NFFT  = 64,
    localparam int AW   = $clog2(2 * NFFT)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2*NFFT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Holding rd_data while rd_en is low lets the top freeze its pipeline
    // on downstream back-pressure without re-issuing the read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ofdm_cp_inserter.sv
// ofdm_cp_inserter
//   Cyclic-prefix inserter: buffers NFFT-sample symbols into a ping-pong RAM
//   and emits the last L samples followed by the whole symbol (L = cp_len
//   latched at sop, clamped to MAX_CP).
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     in_valid/in_ready/in_sop     input stream handshake and symbol start
//     in_real, in_imag, cp_len     input sample and per-symbol CP length
//     out_valid/out_ready          output stream handshake
//     out_sop, out_eop             first/last sample of an extended symbol
//     out_real, out_imag           output sample (bit-exact copy)
//     frame_err                    one-cycle pulse on sop received mid-symbol
//   Optional feature macro: OFDM_CP_SUFFIX_EN appends a cyclic suffix of
//   floor(L/2) samples (indices 0..L/2-1) after the body.
module ofdm_cp_inserter
    import ofdm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NFFT   = 64,
    parameter int MAX_CP = 16,
    parameter int CP_W   = $clog2(MAX_CP + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic [CP_W-1:0]   cp_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              frame_err
);

    localparam int AW    = $clog2(NFFT);
    localparam int WIDTH = 2 * DATA_W;

    wr_state_t         wr_state, wr_state_nxt;
    logic [AW-1:0]     wr_idx, wr_idx_nxt, ram_wr_idx;
    logic              wr_bank, wr_bank_nxt;
    logic              ready_en, accept, ram_wr_en, latch_cp, fill_done, ferr_nxt;
    logic [CP_W-1:0]   cp_clamped;
    logic [CP_W-1:0]   cp_lat [2];
`ifdef OFDM_CP_SUFFIX_EN
    logic [CP_W-2:0]   ls_lat [2];
`endif
    logic [1:0]        full;
    logic              free_bank;

    rd_state_t         rd_state, rd_state_nxt, eff_state;
    logic [AW-1:0]     rd_ptr, rd_ptr_nxt, eff_idx;
    logic              rd_bank, rd_bank_nxt;
    logic              issue, iss_sop, iss_eop, adv;
    logic              s1_valid, s1_sop, s1_eop;
    logic [WIDTH-1:0]  ram_rd_data;

    // ready_en delays in_ready by one cycle after reset release.
    assign in_ready   = ready_en && !full[wr_bank];
    assign accept     = in_valid && in_ready;
    assign cp_clamped = (cp_len > CP_W'(MAX_CP)) ? CP_W'(MAX_CP) : cp_len;
    // The whole read pipeline freezes while the output register is stalled.
    assign adv        = !out_valid || out_ready;

    // A sop always restarts the current bank at index 0, whatever the state.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_idx_nxt   = wr_idx;
        wr_bank_nxt  = wr_bank;
        ram_wr_en    = 1'b0;
        ram_wr_idx   = wr_idx;
        latch_cp     = 1'b0;
        fill_done    = 1'b0;
        ferr_nxt     = 1'b0;
        if (accept) begin
            if (in_sop) begin
                ram_wr_en    = 1'b1;
                ram_wr_idx   = '0;
                latch_cp     = 1'b1;
                wr_idx_nxt   = AW'(1);
                wr_state_nxt = W_FILL;
                ferr_nxt     = (wr_state == W_FILL);
            end else if (wr_state == W_FILL) begin
                ram_wr_en = 1'b1;
                if (wr_idx == AW'(NFFT - 1)) begin
                    fill_done    = 1'b1;
                    wr_bank_nxt  = ~wr_bank;
                    wr_idx_nxt   = '0;
                    wr_state_nxt = W_HUNT;
                end else begin
                    wr_idx_nxt = wr_idx + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state  <= W_HUNT;
            wr_idx    <= '0;
            wr_bank   <= 1'b0;
            ready_en  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_state  <= wr_state_nxt;
            wr_idx    <= wr_idx_nxt;
            wr_bank   <= wr_bank_nxt;
            ready_en  <= 1'b1;
            frame_err <= ferr_nxt;
        end
    end

    // Banks are freed in fill order when their eop leaves the output, so
    // a single toggling pointer tracks which one to release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full      <= '0;
            free_bank <= 1'b0;
            cp_lat[0] <= '0;
            cp_lat[1] <= '0;
`ifdef OFDM_CP_SUFFIX_EN
            ls_lat[0] <= '0;
            ls_lat[1] <= '0;
`endif
        end else begin
            if (fill_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (out_valid && out_ready && out_eop) begin
                full[free_bank] <= 1'b0;
                free_bank       <= ~free_bank;
            end
            if (latch_cp) begin
                cp_lat[wr_bank] <= cp_clamped;
`ifdef OFDM_CP_SUFFIX_EN
                ls_lat[wr_bank] <= cp_clamped[CP_W-1:1];
`endif
            end
        end
    end

    // IDLE with a full bank is treated as the first CP/BODY cycle, so the
    // first read issues in the same cycle the bank is seen full and a new
    // symbol follows the previous eop without a bubble.
    always_comb begin
        eff_state    = rd_state;
        eff_idx      = rd_ptr;
        rd_state_nxt = rd_state;
        rd_ptr_nxt   = rd_ptr;
        rd_bank_nxt  = rd_bank;
        issue        = 1'b0;
        iss_sop      = 1'b0;
        iss_eop      = 1'b0;
        if (rd_state == R_IDLE && full[rd_bank]) begin
            iss_sop = 1'b1;
            if (cp_lat[rd_bank] != '0) begin
                eff_state = R_CP;
                eff_idx   = AW'(NFFT - int'(cp_lat[rd_bank]));
            end else begin
                eff_state = R_BODY;
                eff_idx   = '0;
            end
        end
        case (eff_state)
            R_CP: begin
                issue = 1'b1;
                if (eff_idx == AW'(NFFT - 1)) begin
                    rd_state_nxt = R_BODY;
                    rd_ptr_nxt   = '0;
                end else begin
                    rd_state_nxt = R_CP;
                    rd_ptr_nxt   = eff_idx + AW'(1);
                end
            end
            R_BODY: begin
                issue = 1'b1;
                if (eff_idx == AW'(NFFT - 1)) begin
`ifdef OFDM_CP_SUFFIX_EN
                    if (ls_lat[rd_bank] != '0) begin
                        rd_state_nxt = R_SUFFIX;
                        rd_ptr_nxt   = '0;
                    end else begin
                        iss_eop = 1'b1;
                    end
`else
                    iss_eop = 1'b1;
`endif
                end else begin
                    rd_state_nxt = R_BODY;
                    rd_ptr_nxt   = eff_idx + AW'(1);
                end
            end
`ifdef OFDM_CP_SUFFIX_EN
            R_SUFFIX: begin
                issue = 1'b1;
                if (int'(eff_idx) == int'(ls_lat[rd_bank]) - 1) begin
                    iss_eop = 1'b1;
                end else begin
                    rd_state_nxt = R_SUFFIX;
                    rd_ptr_nxt   = eff_idx + AW'(1);
                end
            end
`endif
            default: ;
        endcase
        if (iss_eop) begin
            rd_state_nxt = R_IDLE;
            rd_ptr_nxt   = '0;
            rd_bank_nxt  = ~rd_bank;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= R_IDLE;
            rd_ptr   <= '0;
            rd_bank  <= 1'b0;
        end else if (adv) begin
            rd_state <= rd_state_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_bank  <= rd_bank_nxt;
        end
    end

    // Stage 1 tracks the RAM read register; stage 2 is the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
        end else if (adv) begin
            s1_valid  <= issue;
            s1_sop    <= iss_sop;
            s1_eop    <= iss_eop;
            out_valid <= s1_valid;
            out_sop   <= s1_sop;
            out_eop   <= s1_eop;
            out_real  <= ram_rd_data[WIDTH-1:DATA_W];
            out_imag  <= ram_rd_data[DATA_W-1:0];
        end
    end

    ofdm_pingpong_ram #(
        .WIDTH (WIDTH),
        .NFFT  (NFFT)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr ({wr_bank, ram_wr_idx}),
        .wr_data ({in_real, in_imag}),
        .rd_en   (adv),
        .rd_addr ({rd_bank, eff_idx}),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// tb_ofdm_cp_inserter
//   Self-checking bench for ofdm_cp_inserter (NFFT=64, MAX_CP=16).
//   A behavioural model of the framing rules builds the expected CP-extended
//   symbols into a scoreboard queue as input samples are accepted; a monitor
//   pops and compares every accepted output sample.
//   Honours OFDM_CP_SUFFIX_EN when building expected symbols.
module tb_ofdm_cp_inserter;
    import ofdm_pkg::*;

    localparam int DATA_W = DATA_W_DEF;
    localparam int NFFT   = 64;
    localparam int MAX_CP = 16;
    localparam int CP_W   = $clog2(MAX_CP + 1);
`ifdef OFDM_CP_SUFFIX_EN
    localparam int LS_16 = 8;
`else
    localparam int LS_16 = 0;
`endif

    logic              clk, reset_n;
    logic              in_valid, in_ready, in_sop;
    logic [DATA_W-1:0] in_real, in_imag;
    logic [CP_W-1:0]   cp_len;
    logic              out_valid, out_ready, out_sop, out_eop, frame_err;
    logic [DATA_W-1:0] out_real, out_imag;

    ofdm_cp_inserter #(
        .DATA_W (DATA_W),
        .NFFT   (NFFT),
        .MAX_CP (MAX_CP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .cp_len    (cp_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        sample_t smp;
        logic    sop;
        logic    eop;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    sample_t     m_buf [NFFT];
    bit          m_fill = 0;
    int          m_idx = 0;
    int          m_cp = 0;
    int          sym_done = 0;
    int          sym_freed = 0;
    int          ferr_exp = 0;
    int          ferr_seen = 0;
    int          pop_cnt = 0;
    bit          rand_ready = 0;
    bit          gap_chk = 0;
    bit          want_sop = 0;
    bit          prev_stall = 0;
    bit          ferr_prev = 0;
    logic [63:0] held_vec = '0;
    int          stalls [5];

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected output order: tail of length L, full body, then (optionally)
    // the first floor(L/2) samples again.
    task automatic pushSymbol();
        int   l = m_cp;
        int   ls = 0;
        int   total, idx;
        exp_t e;
`ifdef OFDM_CP_SUFFIX_EN
        ls = m_cp / 2;
`endif
        total = l + NFFT + ls;
        for (int j = 0; j < total; j++) begin
            if (j < l) idx = NFFT - l + j;
            else if (j < l + NFFT) idx = j - l;
            else idx = j - l - NFFT;
            e.smp = m_buf[idx];
            e.sop = (j == 0);
            e.eop = (j == total - 1);
            sb_q.push_back(e);
        end
        sym_done <= sym_done + 1;
    endtask

    task automatic modelAccept(input logic sop, input logic [DATA_W-1:0] re,
                               input logic [DATA_W-1:0] im, input int cp);
        if (sop) begin
            if (m_fill) ferr_exp++;
            m_fill = 1;
            m_buf[0].re = re;
            m_buf[0].im = im;
            m_idx = 1;
            m_cp = (cp > MAX_CP) ? MAX_CP : cp;
        end else if (m_fill) begin
            m_buf[m_idx].re = re;
            m_buf[m_idx].im = im;
            m_idx++;
            if (m_idx == NFFT) begin
                pushSymbol();
                m_fill = 0;
            end
        end
    endtask

    // Called and returns just after a rising edge.
    task automatic applyStimulus(input logic sop, input logic [DATA_W-1:0] re,
                                 input logic [DATA_W-1:0] im, input int cp,
                                 output int nstall);
        int guard = 0;
        nstall   = 0;
        in_valid = 1;
        in_sop   = sop;
        in_real  = re;
        in_imag  = im;
        cp_len   = CP_W'(cp);
        @(negedge clk);
        while (!in_ready && guard < 2000) begin
            nstall++;
            guard++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        else modelAccept(sop, re, im, cp);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_sop   = 0;
    endtask

    task automatic sendSymbol(input int cp, input int base, input bit rnd,
                              input int nsamp, output int stall_sum);
        logic [DATA_W-1:0] re, im;
        int st;
        stall_sum = 0;
        for (int k = 0; k < nsamp; k++) begin
            re = rnd ? DATA_W'($urandom) : DATA_W'(base + k);
            im = rnd ? DATA_W'($urandom) : DATA_W'(-(base + k));
            applyStimulus(k == 0, re, im, cp, st);
            stall_sum += st;
        end
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        checkOutput("drain", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        sb_q.delete();
        m_fill = 0;
        m_idx  = 0;
        pop_cnt = 0;
        sym_done  <= 0;
        sym_freed <= 0;
    endtask

    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard compare, hold-under-stall, no-bubble,
    // in_ready while both banks are full, frame_err pulse width.
    always @(negedge clk) begin
        logic [63:0] cur_vec;
        exp_t e;
        cur_vec = {out_valid, out_sop, out_eop, out_real, out_imag};
        if (!reset_n) begin
            prev_stall = 0;
            want_sop   = 0;
            ferr_prev  = 0;
        end else begin
            if (want_sop) begin
                checkOutput("no_bubble", {out_valid, out_sop}, 2'b11);
                want_sop = 0;
            end
            if (prev_stall) checkOutput("stall_hold", cur_vec, held_vec);
            if (sym_done - sym_freed >= 2) checkOutput("ready_when_full", in_ready, 0);
            if (frame_err) begin
                ferr_seen++;
                checkOutput("ferr_width", ferr_prev, 0);
            end
            ferr_prev = frame_err;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_out", {out_real, out_imag}, 'x);
                end else begin
                    e = sb_q.pop_front();
                    pop_cnt++;
                    checkOutput("out_data", {out_real, out_imag, out_sop, out_eop},
                                {e.smp.re, e.smp.im, e.sop, e.eop});
                end
                if (out_eop) begin
                    sym_freed <= sym_freed + 1;
                    want_sop = gap_chk && (sb_q.size() > 0);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_vec   = cur_vec;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        clk = 0;
        reset_n = 0;
        in_valid = 0;
        in_sop = 0;
        in_real = '0;
        in_imag = '0;
        cp_len = '0;
        out_ready = 1;

        $display("[TB] reset checks");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {out_valid, out_sop, out_eop, frame_err, in_ready, out_real, out_imag}, '0);
        @(negedge clk);
        reset_n = 1;
        #1;
        checkOutput("ready_at_release", in_ready, 0);
        @(negedge clk);
        checkOutput("ready_one_cycle_later", in_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] ramp symbol, cp=16, latency");
        sendSymbol(16, 0, 0, NFFT, st);
        @(negedge clk);
        checkOutput("latency_c1", out_valid, 0);
        @(negedge clk);
        checkOutput("latency_c2", out_valid, 0);
        @(negedge clk);
        checkOutput("latency_c3", out_valid, 1);
        waitDrain();

        $display("[TB] cp=0 then cp=20 (clamped)");
        sendSymbol(0, 0, 0, NFFT, st);
        sendSymbol(20, 0, 0, NFFT, st);
        waitDrain();

        $display("[TB] continuous input, back-to-back output");
        gap_chk = 1;
        for (int s = 0; s < 5; s++) sendSymbol(16, s * 100, 0, NFFT, stalls[s]);
        checkOutput("steady_stall_sym3", stalls[3], 16 + LS_16);
        checkOutput("steady_stall_sym4", stalls[4], 16 + LS_16);
        waitDrain();
        gap_chk = 0;

        $display("[TB] random out_ready");
        rand_ready = 1;
        sendSymbol(5, 0, 1, NFFT, st);
        sendSymbol(16, 0, 1, NFFT, st);
        sendSymbol(9, 0, 1, NFFT, st);
        sendSymbol(13, 0, 1, NFFT, st);
        waitDrain();
        rand_ready = 0;
        out_ready = 1;

        $display("[TB] sop mid-symbol");
        sendSymbol(8, 1000, 0, 30, st);
        sendSymbol(4, 0, 0, NFFT, st);
        waitDrain();
        checkOutput("ferr_count", ferr_seen, ferr_exp);

        $display("[TB] reset mid-body");
        pop_cnt = 0;
        sendSymbol(16, 200, 0, NFFT, st);
        for (int g = 0; g < 500 && pop_cnt < 30; g++) @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        checkOutput("async_reset_outputs",
                    {out_valid, out_sop, out_eop, frame_err, in_ready, out_real, out_imag}, '0);
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) applyStimulus(0, DATA_W'(500 + k), DATA_W'(k), 4, st);
        sendSymbol(4, 300, 0, NFFT, st);
        waitDrain();
        repeat (20) @(posedge clk);
        checkOutput("no_residual", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
